// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: decodes RAM / LED register / switch port, inserts
// WAIT_STATES wait cycles, then returns registered read data with a one-cycle ack.
//
//   state | meaning
//   IDLE  | waiting for req; accepts and captures addr/wr/wdata
//   WAIT  | counting down the programmed wait states
//   RESP  | ack/err/rdata valid; RAM or LED write commits at end of cycle
module mem_bus_responder #(
    parameter int          DATA_W      = 16,
    parameter int          ADDR_W      = 16,
    parameter int          RAM_AW      = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [3:0]  LED_PAGE    = 4'h1,
    parameter logic [3:0]  SW_PAGE     = 4'h3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic [7:0]        led,
    input  logic [7:0]        sw
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        cnt;
    logic [7:0]        sw_s1;
    logic [7:0]        sw_s2;
    logic [DATA_W-1:0] ram [0:(1<<RAM_AW)-1];

    logic [ADDR_W-1:0] cur_addr;
    logic              cur_wr;
    logic [3:0]        page;
    logic              hit_ram;
    logic              hit_led;
    logic              hit_sw;
    logic              resp_go;

    // In IDLE the live request is decoded so a zero-wait access can respond on
    // the accepting edge; otherwise the captured request is used.
    always_comb begin
        cur_addr = (state == IDLE) ? addr : addr_q;
        cur_wr   = (state == IDLE) ? wr : wr_q;
        page     = cur_addr[ADDR_W-1 -: 4];
        hit_ram  = (cur_addr >> RAM_AW) == '0;
        hit_led  = !hit_ram && (page == LED_PAGE);
        hit_sw   = !hit_ram && !hit_led && (page == SW_PAGE);
        resp_go  = ((state == IDLE) && req && (WS == 4'd0)) ||
                   ((state == WAIT) && (cnt == 4'd1));
    end

    assign busy = (state == WAIT) || (state == RESP);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            led     <= 8'h00;
            cnt     <= 4'd0;
            sw_s1   <= 8'h00;
            sw_s2   <= 8'h00;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
            ack   <= 1'b0;
            err   <= 1'b0;

            // Registered response: the RAM read lands directly in rdata here.
            if (resp_go) begin
                ack <= 1'b1;
                err <= !(hit_ram || hit_led || hit_sw) || (cur_wr && hit_sw);
                if (!cur_wr) begin
                    if (hit_ram)
                        rdata <= ram[cur_addr[RAM_AW-1:0]];
                    else if (hit_led)
                        rdata <= DATA_W'(led);
                    else if (hit_sw)
                        rdata <= DATA_W'(sw_s2);
                    else
                        rdata <= '0;
                end
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        wr_q    <= wr;
                        wdata_q <= wdata;
                        cnt     <= WS;
                        state   <= (WS == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= RESP;
                end
                RESP: begin
                    if (wr_q && hit_led)
                        led <= wdata_q[7:0];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && (state == RESP) && wr_q && hit_ram)
            ram[addr_q[RAM_AW-1:0]] <= wdata_q;
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: one instance with one wait state and
// one with zero wait states for the back-to-back request case.
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        s_req = 1'b0, s_wr = 1'b0;
    logic [15:0] s_addr = '0, s_wdata = '0, s_rdata;
    logic        s_ack, s_err, s_busy;
    logic [7:0]  s_led, s_sw = 8'h00;

    logic        f_req = 1'b0, f_wr = 1'b0;
    logic [15:0] f_addr = '0, f_wdata = '0, f_rdata;
    logic        f_ack, f_err, f_busy;
    logic [7:0]  f_led, f_sw = 8'h00;

    int n_chk = 0;
    int n_fail = 0;
    bit f_sb_on = 1'b0;

    typedef struct {
        string       tag;
        logic [15:0] rd;
        logic        er;
    } exp_t;

    exp_t q_s[$];
    exp_t q_f[$];

    always #5 clk = ~clk;

    mem_bus_responder #(.WAIT_STATES(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .req(s_req), .wr(s_wr), .addr(s_addr),
        .wdata(s_wdata), .rdata(s_rdata), .ack(s_ack), .err(s_err),
        .busy(s_busy), .led(s_led), .sw(s_sw)
    );

    mem_bus_responder #(.WAIT_STATES(0)) u_fast (
        .clk(clk), .reset_n(reset_n), .req(f_req), .wr(f_wr), .addr(f_addr),
        .wdata(f_wdata), .rdata(f_rdata), .ack(f_ack), .err(f_err),
        .busy(f_busy), .led(f_led), .sw(f_sw)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ack pops the oldest expectation of its instance.
    always @(negedge clk) begin
        exp_t e;
        if (s_ack) begin
            if (q_s.size() == 0) begin
                check("s_unexpected_ack", 1, 0);
            end else begin
                e = q_s.pop_front();
                check({e.tag, "_rdata"}, s_rdata, e.rd);
                check({e.tag, "_err"}, s_err, e.er);
            end
        end
        if (f_ack && f_sb_on) begin
            if (q_f.size() == 0) begin
                check("f_unexpected_ack", 1, 0);
            end else begin
                e = q_f.pop_front();
                check({e.tag, "_rdata"}, f_rdata, e.rd);
                check({e.tag, "_err"}, f_err, e.er);
            end
        end
    end

    task automatic txn(input bit fast, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] erd,
                       input logic eer, input string tag);
        exp_t e;
        int   n;
        logic a_now;
        e.tag = tag;
        e.rd  = erd;
        e.er  = eer;
        @(negedge clk);
        if (fast) begin
            q_f.push_back(e);
            f_req = 1'b1; f_wr = w; f_addr = a; f_wdata = d;
        end else begin
            q_s.push_back(e);
            s_req = 1'b1; s_wr = w; s_addr = a; s_wdata = d;
        end
        @(posedge clk);
        #1;
        // Scramble the bus after accept; the captured request must be used.
        if (fast) begin
            f_req = 1'b0; f_wr = ~w; f_addr = 16'hFFFF; f_wdata = 16'h5A5A;
        end else begin
            s_req = 1'b0; s_wr = ~w; s_addr = 16'hFFFF; s_wdata = 16'h5A5A;
        end
        n = 0;
        a_now = 1'b0;
        while (!a_now && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1)
                check({tag, "_busy"}, fast ? f_busy : s_busy, 1);
            a_now = fast ? f_ack : s_ack;
        end
        check({tag, "_latency"}, n, fast ? 1 : 2);
        @(negedge clk);
        check({tag, "_ack_single"}, fast ? f_ack : s_ack, 0);
        check({tag, "_idle_busy"}, fast ? f_busy : s_busy, 0);
    endtask

    initial begin
        int acks;
        logic prev;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", s_ack, 0);
        check("rst_err", s_err, 0);
        check("rst_rdata", s_rdata, 16'h0000);
        check("rst_led", s_led, 8'h00);
        check("rst_busy", s_busy, 0);
        reset_n = 1'b1;

        txn(0, 1, 16'h0005, 16'hBEEF, 16'h0000, 0, "wr_ram5");
        txn(0, 0, 16'h0005, 16'h0000, 16'hBEEF, 0, "rd_ram5");

        txn(0, 1, 16'h1000, 16'h00A5, 16'hBEEF, 0, "wr_led");
        check("led_after_ack", s_led, 8'hA5);
        txn(0, 0, 16'h1000, 16'h0000, 16'h00A5, 0, "rd_led");

        s_sw = 8'h3C;
        repeat (3) @(posedge clk);
        txn(0, 0, 16'h3000, 16'h0000, 16'h003C, 0, "rd_sw");
        txn(0, 1, 16'h3000, 16'h5555, 16'h003C, 1, "wr_sw");
        check("led_after_wr_sw", s_led, 8'hA5);
        txn(0, 0, 16'h0005, 16'h0000, 16'hBEEF, 0, "rd_ram5_again");

        txn(0, 0, 16'h8000, 16'h0000, 16'h0000, 1, "rd_unmapped");
        txn(0, 0, 16'h0005, 16'h0000, 16'hBEEF, 0, "rd_ram5_third");
        txn(0, 1, 16'h8000, 16'h7777, 16'hBEEF, 1, "wr_unmapped");
        check("led_after_wr_unmapped", s_led, 8'hA5);

        // Zero wait states, request held high continuously.
        f_sb_on = 1'b1;
        txn(1, 1, 16'h0021, 16'h0000, 16'h0000, 0, "f_clear21");
        f_sb_on = 1'b0;
        @(negedge clk);
        f_req = 1'b1; f_wr = 1'b1; f_addr = 16'h0020; f_wdata = 16'hCAFE;
        acks = 0;
        prev = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (f_ack) begin
                acks++;
                check("f_ack_not_stretched", prev, 0);
                f_addr = 16'h0021; f_wdata = 16'hDEAD;
            end else begin
                f_addr = 16'h0020; f_wdata = 16'hCAFE;
            end
            prev = f_ack;
        end
        f_req = 1'b0;
        check("f_accept_every_2", acks, 6);
        q_f.delete();
        f_sb_on = 1'b1;
        txn(1, 0, 16'h0020, 16'h0000, 16'hCAFE, 0, "f_rd20");
        txn(1, 0, 16'h0021, 16'h0000, 16'h0000, 0, "f_rd21");
        f_sb_on = 1'b0;

        // Reset during WAIT aborts the write.
        txn(0, 1, 16'h0010, 16'h0000, 16'hBEEF, 0, "wr_ram10_zero");
        @(negedge clk);
        s_req = 1'b1; s_wr = 1'b1; s_addr = 16'h0010; s_wdata = 16'h1234;
        @(posedge clk);
        #1 s_req = 1'b0;
        @(negedge clk);
        check("abort_in_wait", s_busy, 1);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_ack", s_ack, 0);
        check("abort_err", s_err, 0);
        check("abort_rdata", s_rdata, 16'h0000);
        check("abort_led", s_led, 8'h00);
        check("abort_busy", s_busy, 0);
        reset_n = 1'b1;
        txn(0, 0, 16'h0010, 16'h0000, 16'h0000, 0, "rd_ram10_after_abort");

        repeat (2) @(negedge clk);
        check("s_queue_drained", q_s.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
